// File: rtl/serial_bcd_alu.sv
// Bit-serial 4-digit BCD adder/subtractor: takes a 33-bit LSB-first frame
// (A, B, op) and returns a 20-bit, 5-digit BCD result LSB-first.
module serial_bcd_alu (
  input  logic rst,
  input  logic clk,
  input  logic en,
  input  logic in,
  output logic result
);

  typedef enum logic [1:0] {IDLE, RECV, CALC, SEND} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [32:0] frame;
  logic [19:0] out_sr;
  logic [19:0] calc_val;
  logic        calc_c;
  logic [4:0]  calc_r;

  // Returns {decimal carry, digit}.
  function automatic logic [4:0] add_digit(input logic [3:0] a, input logic [3:0] b,
                                           input logic c);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0, c};
    if (s > 5'd9) return {1'b1, s[3:0] + 4'd6};
    else          return s;
  endfunction

  // Returns {decimal borrow, digit}.
  function automatic logic [4:0] sub_digit(input logic [3:0] a, input logic [3:0] b,
                                           input logic bw);
    logic signed [5:0] d;
    d = $signed({2'b0, a}) - $signed({2'b0, b}) - $signed({5'b0, bw});
    if (d < 0) return {1'b1, d[3:0] + 4'd10};
    else       return {1'b0, d[3:0]};
  endfunction

  // Frame holds A in [15:0], B in [31:16], op in [32] once 33 bits are shifted in.
  always_comb begin
    calc_val = '0;
    calc_c   = 1'b0;
    calc_r   = '0;
    for (int i = 0; i < 4; i++) begin
      if (frame[32]) calc_r = sub_digit(frame[4*i +: 4], frame[16+4*i +: 4], calc_c);
      else           calc_r = add_digit(frame[4*i +: 4], frame[16+4*i +: 4], calc_c);
      calc_val[4*i +: 4] = calc_r[3:0];
      calc_c             = calc_r[4];
    end
    calc_val[19:16] = {3'b0, calc_c};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RECV;
      RECV: begin
        if (!en)                state_nxt = IDLE;
        else if (cnt == 6'd32)  state_nxt = CALC;
      end
      CALC: state_nxt = SEND;
      SEND: if (cnt == 6'd20) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      frame  <= '0;
      out_sr <= '0;
      result <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          result <= 1'b0;
          if (en) begin
            frame <= {in, frame[32:1]};
            cnt   <= 6'd1;
          end
        end
        RECV: begin
          result <= 1'b0;
          if (en) begin
            frame <= {in, frame[32:1]};
            cnt   <= cnt + 6'd1;
          end else begin
            cnt <= '0;
          end
        end
        CALC: begin
          result <= calc_val[0];
          out_sr <= {1'b0, calc_val[19:1]};
          cnt    <= 6'd1;
        end
        SEND: begin
          // cnt is the index of the bit being driven next; 20 means the last bit has had its cycle.
          if (cnt == 6'd20) begin
            result <= 1'b0;
            cnt    <= '0;
          end else begin
            result <= out_sr[0];
            out_sr <= {1'b0, out_sr[19:1]};
            cnt    <= cnt + 6'd1;
          end
        end
        default: result <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bcd_alu.sv
// Scoreboard bench for serial_bcd_alu: decimal reference model, queued expected
// words, and a monitor that captures the serial result each cycle.
module tb_serial_bcd_alu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic in  = 1'b0;
  logic result;

  serial_bcd_alu dut (
    .rst    (rst),
    .clk    (clk),
    .en     (en),
    .in     (in),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;      // edge that samples bit 32
    logic [19:0] val;
    int          nbits;  // bits expected before the word is cut short
  } item_t;

  item_t q[$];
  int    ecount = 0;
  int    checks = 0;
  int    fails  = 0;

  always @(posedge clk) ecount <= ecount + 1;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int model(input int a, input int b, input logic op);
    if (!op)        return a + b;
    else if (a >= b) return a - b;
    else            return 20000 + a - b;
  endfunction

  // Monitor: inside an expected window capture bits, otherwise result must be 0.
  logic [19:0] cap;
  logic [19:0] mask;
  int          mj;
  always @(negedge clk) begin
    if (ecount > 0) begin
      if (q.size() > 0 && ecount >= q[0].n + 1 && ecount <= q[0].n + q[0].nbits) begin
        mj = ecount - q[0].n - 1;
        if (mj == 0) cap = '0;
        cap[mj] = result;
        if (mj == q[0].nbits - 1) begin
          mask = (q[0].nbits >= 20) ? 20'hfffff : 20'((1 << q[0].nbits) - 1);
          checks++;
          if ((cap & mask) !== (q[0].val & mask)) begin
            fails++;
            $display("FAIL result_word edge=%0d got=%h exp=%h nbits=%0d",
                     q[0].n, cap & mask, q[0].val & mask, q[0].nbits);
          end
          void'(q.pop_front());
        end
      end else begin
        checks++;
        if (result !== 1'b0) begin
          fails++;
          $display("FAIL idle_zero edge=%0d got=%b exp=0", ecount, result);
        end
      end
    end
  end

  // Drives ncyc cycles of en=1; bits past 32 are random junk. rst_at>0 resets
  // the DUT so that exactly rst_at result bits appear first.
  task automatic send_frame(input int a, input int b, input logic op,
                            input int ncyc, input int rst_at);
    logic [32:0] f;
    logic [19:0] ba, bb;
    int n;
    item_t it;
    ba = to_bcd(a);
    bb = to_bcd(b);
    f  = {op, bb[15:0], ba[15:0]};
    n  = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      en = 1'b1;
      in = (k < 33) ? f[k] : 1'($urandom);
      if (k == 32) begin
        n        = ecount + 1;
        it.n     = n;
        it.val   = to_bcd(model(a, b, op));
        it.nbits = (rst_at > 0) ? rst_at : 20;
        q.push_back(it);
      end
    end
    @(negedge clk);
    en = 1'b0;
    in = 1'b0;
    if (n >= 0 && rst_at > 0) begin
      while (ecount < n + rst_at) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
    end
    if (n >= 0) while (ecount < n + 23) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  function automatic int rand_bcd();
    return $urandom_range(0, 9999);
  endfunction

  initial begin
    // Reset held for two edges while en toggles.
    rst = 1'b0;
    @(negedge clk); en = 1'b1; in = 1'b1;
    @(negedge clk); en = 1'b0; in = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(2172, 4678, 1'b0, 33, 0);   // 06850
    send_frame(4263, 3147, 1'b1, 33, 0);   // 01116
    send_frame(9999, 1,    1'b0, 33, 0);   // 10000
    send_frame(1000, 1001, 1'b1, 33, 0);   // 19999
    send_frame(0,    0,    1'b1, 33, 0);   // 00000
    send_frame(3333, 4444, 1'b0, 10, 0);   // aborted: nothing queued
    send_frame(1234, 5678, 1'b0, 33, 0);   // 06912
    send_frame(5555, 4445, 1'b0, 40, 0);   // en held 40 cycles
    send_frame(8765, 1234, 1'b1, 33, 8);   // reset during SEND
    send_frame(999,  1,    1'b0, 33, 0);   // 01000 after that reset

    for (int i = 0; i < 25; i++)
      send_frame(rand_bcd(), rand_bcd(), 1'($urandom), $urandom_range(33, 40), 0);

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
